// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Purpose : Shared constants for the multicycle MIPS controller: opcode and
//           function-field values, ALUC encodings, FSM state enum, instruction
//           classes, pc_src / ALU operand select codes and fault codes.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package mips_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;

    // ALU operation encodings
    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_AND = 4'b0001;
    localparam logic [3:0] ALUC_XOR = 4'b0010;
    localparam logic [3:0] ALUC_SLL = 4'b0011;
    localparam logic [3:0] ALUC_SUB = 4'b0100;
    localparam logic [3:0] ALUC_OR  = 4'b0101;
    localparam logic [3:0] ALUC_LUI = 4'b0110;
    localparam logic [3:0] ALUC_SRL = 4'b0111;
    localparam logic [3:0] ALUC_SRA = 4'b1111;

    // PC source select
    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    // ALU operand selects
    localparam logic [1:0] SRC_A_PC     = 2'd0;
    localparam logic [1:0] SRC_A_Q1     = 2'd1;
    localparam logic [1:0] SRC_A_SHAMT  = 2'd2;
    localparam logic [1:0] SRC_B_Q2     = 2'd0;
    localparam logic [1:0] SRC_B_FOUR   = 2'd1;
    localparam logic [1:0] SRC_B_IMM    = 2'd2;
    localparam logic [1:0] SRC_B_IMM_SL = 2'd3;

    // Fault codes
    localparam logic [1:0] FAULT_NONE    = 2'd0;
    localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
    localparam logic [1:0] FAULT_BUS     = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_ALU,
        S_WB_MEM,
        S_BRANCH,
        S_JUMP,
        S_FAULT
    } state_t;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_MEM,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_ILLEGAL
    } instr_class_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// -----------------------------------------------------------------------------
// mips_ctrl_decode
// Purpose : Combinational instruction classifier for the multicycle controller.
// Ports   : i_op      [5:0]  opcode field
//           i_func    [5:0]  R-type function field
//           o_class   [2:0]  instruction class (instr_class_t encoding)
//           o_aluc    [3:0]  ALU operation for the execute step
//           o_sext           1 = sign-extend immediate in EXEC_I
//           o_shift          R-type shift (ALU A operand is shamt)
//           o_is_lw          memory class is a load
//           o_is_bne         branch class is BNE
//           o_illegal        op/func pair matches no decoded instruction
// -----------------------------------------------------------------------------
module mips_ctrl_decode
    import mips_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [5:0] i_func,
    output logic [2:0] o_class,
    output logic [3:0] o_aluc,
    output logic       o_sext,
    output logic       o_shift,
    output logic       o_is_lw,
    output logic       o_is_bne,
    output logic       o_illegal
);

    always_comb begin
        o_class  = CLS_ILLEGAL;
        o_aluc   = ALUC_ADD;
        o_sext   = 1'b0;
        o_shift  = 1'b0;
        o_is_lw  = 1'b0;
        o_is_bne = 1'b0;

        case (i_op)
            OP_RTYPE: begin
                o_class = CLS_R;
                case (i_func)
                    FN_ADD:  o_aluc = ALUC_ADD;
                    FN_SUB:  o_aluc = ALUC_SUB;
                    FN_AND:  o_aluc = ALUC_AND;
                    FN_OR:   o_aluc = ALUC_OR;
                    FN_XOR:  o_aluc = ALUC_XOR;
                    FN_SLL:  begin o_aluc = ALUC_SLL; o_shift = 1'b1; end
                    FN_SRL:  begin o_aluc = ALUC_SRL; o_shift = 1'b1; end
                    FN_SRA:  begin o_aluc = ALUC_SRA; o_shift = 1'b1; end
                    default: o_class = CLS_ILLEGAL;
                endcase
            end
            OP_ADDI: begin o_class = CLS_I; o_aluc = ALUC_ADD; o_sext = 1'b1; end
            OP_ANDI: begin o_class = CLS_I; o_aluc = ALUC_AND; end
            OP_ORI:  begin o_class = CLS_I; o_aluc = ALUC_OR;  end
            OP_XORI: begin o_class = CLS_I; o_aluc = ALUC_XOR; end
            OP_LUI:  begin o_class = CLS_I; o_aluc = ALUC_LUI; end
            OP_LW:   begin o_class = CLS_MEM; o_sext = 1'b1; o_is_lw = 1'b1; end
            OP_SW:   begin o_class = CLS_MEM; o_sext = 1'b1; end
            OP_BEQ:  begin o_class = CLS_BRANCH; o_aluc = ALUC_SUB; end
            OP_BNE:  begin o_class = CLS_BRANCH; o_aluc = ALUC_SUB; o_is_bne = 1'b1; end
            OP_J:    o_class = CLS_JUMP;
            default: o_class = CLS_ILLEGAL;
        endcase

        o_illegal = (o_class == CLS_ILLEGAL);
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
// Purpose : Multicycle sequencer for the MIPS datapath. One FSM walks each
//           instruction through FETCH/DECODE/EXEC/MEM/WB over a single shared
//           memory port with wait states, counts retired instructions and
//           raises sticky faults (illegal instruction, bus timeout).
// Params  : MEM_WAIT_MAX  consecutive not-ready cycles before bus timeout (1..255)
//           TRAP_ILLEGAL  1: undecoded instruction faults; 0: retired as NOP
// Ports   : i_clock, i_reset (async, active-high)
//           i_run, i_op[5:0], i_func[5:0], i_zero, i_mem_ready
//           o_pc_write, o_pc_src[1:0], o_ir_write, o_iord, o_mem_read,
//           o_mem_write, o_reg_write, o_regrt, o_mem2reg, o_alu_src_a[1:0],
//           o_alu_src_b[1:0], o_aluc[3:0], o_sext, o_halted, o_fault,
//           o_fault_code[1:0], o_instret[31:0]
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter int TRAP_ILLEGAL = 1
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_run,
    input  logic [5:0]  i_op,
    input  logic [5:0]  i_func,
    input  logic        i_zero,
    input  logic        i_mem_ready,
    output logic        o_pc_write,
    output logic [1:0]  o_pc_src,
    output logic        o_ir_write,
    output logic        o_iord,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic        o_reg_write,
    output logic        o_regrt,
    output logic        o_mem2reg,
    output logic [1:0]  o_alu_src_a,
    output logic [1:0]  o_alu_src_b,
    output logic [3:0]  o_aluc,
    output logic        o_sext,
    output logic        o_halted,
    output logic        o_fault,
    output logic [1:0]  o_fault_code,
    output logic [31:0] o_instret
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    state_t      r_state;
    logic [7:0]  r_wait;
    logic [31:0] r_instret;
    logic [1:0]  r_fault_code;

    state_t      w_next_state;
    logic        w_complete;
    logic        w_enter_fault;
    logic [1:0]  w_new_fault_code;
    logic        w_mem_state;

    logic [2:0]  w_class;
    logic [3:0]  w_aluc;
    logic        w_sext;
    logic        w_shift;
    logic        w_is_lw;
    logic        w_is_bne;
    logic        w_illegal;

    mips_ctrl_decode u_decode (
        .i_op      (i_op),
        .i_func    (i_func),
        .o_class   (w_class),
        .o_aluc    (w_aluc),
        .o_sext    (w_sext),
        .o_shift   (w_shift),
        .o_is_lw   (w_is_lw),
        .o_is_bne  (w_is_bne),
        .o_illegal (w_illegal)
    );

    // NOTE: every output and next-state signal gets a default before the case,
    // so no path through the block leaves one unassigned and no latch appears.
    always_comb begin
        w_next_state     = r_state;
        w_complete       = 1'b0;
        w_enter_fault    = 1'b0;
        w_new_fault_code = FAULT_NONE;
        w_mem_state      = 1'b0;

        o_pc_write  = 1'b0;
        o_pc_src    = PC_SRC_ALU;
        o_ir_write  = 1'b0;
        o_iord      = 1'b0;
        o_mem_read  = 1'b0;
        o_mem_write = 1'b0;
        o_reg_write = 1'b0;
        o_regrt     = 1'b0;
        o_mem2reg   = 1'b0;
        o_alu_src_a = SRC_A_PC;
        o_alu_src_b = SRC_B_Q2;
        o_aluc      = ALUC_ADD;
        o_sext      = 1'b0;
        o_halted    = 1'b0;

        case (r_state)
            S_IDLE: begin
                o_halted = 1'b1;
                if (i_run) w_next_state = S_FETCH;
            end
            S_FETCH: begin
                w_mem_state = 1'b1;
                o_mem_read  = 1'b1;
                o_alu_src_a = SRC_A_PC;
                o_alu_src_b = SRC_B_FOUR;
                // PC+4 and IR are both captured in the cycle the read completes.
                if (i_mem_ready) begin
                    o_ir_write   = 1'b1;
                    o_pc_write   = 1'b1;
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is computed speculatively while decoding.
                o_alu_src_a = SRC_A_PC;
                o_alu_src_b = SRC_B_IMM_SL;
                o_sext      = 1'b1;
                if (w_illegal) begin
                    if (TRAP_ILLEGAL != 0) begin
                        w_next_state     = S_FAULT;
                        w_enter_fault    = 1'b1;
                        w_new_fault_code = FAULT_ILLEGAL;
                    end else begin
                        w_complete = 1'b1;
                    end
                end else begin
                    case (w_class)
                        CLS_R:      w_next_state = S_EXEC_R;
                        CLS_I:      w_next_state = S_EXEC_I;
                        CLS_MEM:    w_next_state = S_MEM_ADDR;
                        CLS_BRANCH: w_next_state = S_BRANCH;
                        CLS_JUMP:   w_next_state = S_JUMP;
                        default:    w_next_state = S_FAULT;
                    endcase
                end
            end
            S_EXEC_R: begin
                o_alu_src_a  = w_shift ? SRC_A_SHAMT : SRC_A_Q1;
                o_alu_src_b  = SRC_B_Q2;
                o_aluc       = w_aluc;
                w_next_state = S_WB_ALU;
            end
            S_EXEC_I: begin
                o_alu_src_a  = SRC_A_Q1;
                o_alu_src_b  = SRC_B_IMM;
                o_aluc       = w_aluc;
                o_sext       = w_sext;
                o_regrt      = 1'b1;
                w_next_state = S_WB_ALU;
            end
            S_MEM_ADDR: begin
                o_alu_src_a  = SRC_A_Q1;
                o_alu_src_b  = SRC_B_IMM;
                o_sext       = 1'b1;
                w_next_state = w_is_lw ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                w_mem_state = 1'b1;
                o_iord      = 1'b1;
                o_mem_read  = 1'b1;
                if (i_mem_ready) w_next_state = S_WB_MEM;
            end
            S_MEM_WR: begin
                w_mem_state = 1'b1;
                o_iord      = 1'b1;
                o_mem_write = 1'b1;
                if (i_mem_ready) w_complete = 1'b1;
            end
            S_WB_ALU: begin
                o_reg_write = 1'b1;
                o_regrt     = (w_class != CLS_R);
                w_complete  = 1'b1;
            end
            S_WB_MEM: begin
                o_reg_write = 1'b1;
                o_regrt     = 1'b1;
                o_mem2reg   = 1'b1;
                w_complete  = 1'b1;
            end
            S_BRANCH: begin
                o_alu_src_a = SRC_A_Q1;
                o_alu_src_b = SRC_B_Q2;
                o_aluc      = ALUC_SUB;
                o_pc_src    = PC_SRC_BRANCH;
                o_pc_write  = w_is_bne ? !i_zero : i_zero;
                w_complete  = 1'b1;
            end
            S_JUMP: begin
                o_pc_src   = PC_SRC_JUMP;
                o_pc_write = 1'b1;
                w_complete = 1'b1;
            end
            S_FAULT: begin
                w_next_state = S_FAULT;
            end
            default: w_next_state = S_IDLE;
        endcase

        if (w_complete) w_next_state = i_run ? S_FETCH : S_IDLE;

        // Bus timeout: this is the MEM_WAIT_MAX-th consecutive not-ready cycle.
        if (w_mem_state && !i_mem_ready && (r_wait == WAIT_LAST)) begin
            w_next_state     = S_FAULT;
            w_enter_fault    = 1'b1;
            w_new_fault_code = FAULT_BUS;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_wait       <= '0;
            r_instret    <= '0;
            r_fault_code <= FAULT_NONE;
        end else begin
            r_state   <= w_next_state;
            r_instret <= r_instret + 32'(w_complete);
            if (w_enter_fault) r_fault_code <= w_new_fault_code;
            if (w_mem_state && !i_mem_ready && (w_next_state == r_state))
                r_wait <= r_wait + 8'd1;
            else
                r_wait <= '0;
        end
    end

    assign o_fault      = (r_state == S_FAULT);
    assign o_fault_code = r_fault_code;
    assign o_instret    = r_instret;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
// Purpose : Self-checking bench for mips_multicycle_ctrl. A per-cycle table of
//           {inputs, expected control word, expected instret} is applied through
//           a scoreboard queue; hand-written sequences cover illegal-op trap vs
//           NOP, bus timeout and reset in the middle of a store.
//           u_dut uses TRAP_ILLEGAL=1, u_dut_nop TRAP_ILLEGAL=0 (same inputs).
// -----------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;
    import mips_pkg::*;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       regrt;
        logic       mem2reg;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [3:0] aluc;
        logic       sext;
        logic       halted;
        logic       fault;
        logic [1:0] fault_code;
    } ctl_t;

    typedef struct {
        logic        run;
        logic [5:0]  op;
        logic [5:0]  func;
        logic        zero;
        logic        rdy;
        ctl_t        ctl;
        logic [31:0] instret;
        string       name;
    } vec_t;

    typedef struct {
        ctl_t        ctl;
        logic [31:0] instret;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run_i = 1'b0;
    logic [5:0] op_i = '0;
    logic [5:0] func_i = '0;
    logic zero_i = 1'b0;
    logic rdy_i = 1'b0;

    always #5 clk = ~clk;

    // Primary DUT (illegal instructions trap)
    logic        d0_pc_write, d0_ir_write, d0_iord, d0_mem_read, d0_mem_write;
    logic        d0_reg_write, d0_regrt, d0_mem2reg, d0_sext, d0_halted, d0_fault;
    logic [1:0]  d0_pc_src, d0_src_a, d0_src_b, d0_fault_code;
    logic [3:0]  d0_aluc;
    logic [31:0] d0_instret;
    ctl_t        d0_ctl;

    // Second DUT (illegal instructions retire as NOP)
    logic        d1_pc_write, d1_ir_write, d1_iord, d1_mem_read, d1_mem_write;
    logic        d1_reg_write, d1_regrt, d1_mem2reg, d1_sext, d1_halted, d1_fault;
    logic [1:0]  d1_pc_src, d1_src_a, d1_src_b, d1_fault_code;
    logic [3:0]  d1_aluc;
    logic [31:0] d1_instret;

    mips_multicycle_ctrl #(.MEM_WAIT_MAX(15), .TRAP_ILLEGAL(1)) u_dut (
        .i_clock(clk), .i_reset(rst), .i_run(run_i), .i_op(op_i), .i_func(func_i),
        .i_zero(zero_i), .i_mem_ready(rdy_i),
        .o_pc_write(d0_pc_write), .o_pc_src(d0_pc_src), .o_ir_write(d0_ir_write),
        .o_iord(d0_iord), .o_mem_read(d0_mem_read), .o_mem_write(d0_mem_write),
        .o_reg_write(d0_reg_write), .o_regrt(d0_regrt), .o_mem2reg(d0_mem2reg),
        .o_alu_src_a(d0_src_a), .o_alu_src_b(d0_src_b), .o_aluc(d0_aluc),
        .o_sext(d0_sext), .o_halted(d0_halted), .o_fault(d0_fault),
        .o_fault_code(d0_fault_code), .o_instret(d0_instret)
    );

    mips_multicycle_ctrl #(.MEM_WAIT_MAX(15), .TRAP_ILLEGAL(0)) u_dut_nop (
        .i_clock(clk), .i_reset(rst), .i_run(run_i), .i_op(op_i), .i_func(func_i),
        .i_zero(zero_i), .i_mem_ready(rdy_i),
        .o_pc_write(d1_pc_write), .o_pc_src(d1_pc_src), .o_ir_write(d1_ir_write),
        .o_iord(d1_iord), .o_mem_read(d1_mem_read), .o_mem_write(d1_mem_write),
        .o_reg_write(d1_reg_write), .o_regrt(d1_regrt), .o_mem2reg(d1_mem2reg),
        .o_alu_src_a(d1_src_a), .o_alu_src_b(d1_src_b), .o_aluc(d1_aluc),
        .o_sext(d1_sext), .o_halted(d1_halted), .o_fault(d1_fault),
        .o_fault_code(d1_fault_code), .o_instret(d1_instret)
    );

    assign d0_ctl = {d0_pc_write, d0_pc_src, d0_ir_write, d0_iord, d0_mem_read,
                     d0_mem_write, d0_reg_write, d0_regrt, d0_mem2reg, d0_src_a,
                     d0_src_b, d0_aluc, d0_sext, d0_halted, d0_fault, d0_fault_code};

    int total = 0;
    int bad   = 0;

    vec_t tbl[$];
    exp_t sb[$];

    // Expected control words, one per FSM step, written from the state table.
    ctl_t e_idle, e_fw, e_fr, e_dec, e_xadd, e_xsll, e_xori, e_wbr, e_wbi;
    ctl_t e_maddr, e_mrd, e_mwr, e_wbm, e_brt, e_brn, e_jmp, e_flt1, e_flt2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic run, input logic [5:0] op, input logic [5:0] func,
                       input logic zero, input logic rdy, input ctl_t ctl,
                       input logic [31:0] instret, input string name);
        vec_t v;
        v.run = run; v.op = op; v.func = func; v.zero = zero; v.rdy = rdy;
        v.ctl = ctl; v.instret = instret; v.name = name;
        tbl.push_back(v);
    endtask

    // One clock cycle: drive after the rising edge, push the expectation,
    // sample on the falling edge and compare against the popped entry.
    task automatic cycle(input logic run, input logic [5:0] op, input logic [5:0] func,
                         input logic zero, input logic rdy, input ctl_t ctl,
                         input logic [31:0] instret, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        run_i = run; op_i = op; func_i = func; zero_i = zero; rdy_i = rdy;
        e.ctl = ctl; e.instret = instret; e.name = name;
        sb.push_back(e);
        @(negedge clk);
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({e.name, "_ctl"}, 32'(d0_ctl), 32'(e.ctl));
            check({e.name, "_instret"}, d0_instret, e.instret);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        run_i = 1'b0; op_i = '0; func_i = '0; zero_i = 1'b0; rdy_i = 1'b0;
        #1;
        check("reset_ctl", 32'(d0_ctl), 32'(e_idle));
        check("reset_instret", d0_instret, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        e_idle = '0; e_idle.aluc = ALUC_ADD; e_idle.halted = 1'b1;

        e_fw = '0; e_fw.mem_read = 1'b1; e_fw.src_a = SRC_A_PC;
        e_fw.src_b = SRC_B_FOUR; e_fw.aluc = ALUC_ADD;
        e_fr = e_fw; e_fr.ir_write = 1'b1; e_fr.pc_write = 1'b1;

        e_dec = '0; e_dec.src_a = SRC_A_PC; e_dec.src_b = SRC_B_IMM_SL;
        e_dec.aluc = ALUC_ADD; e_dec.sext = 1'b1;

        e_xadd = '0; e_xadd.src_a = SRC_A_Q1; e_xadd.src_b = SRC_B_Q2; e_xadd.aluc = ALUC_ADD;
        e_xsll = '0; e_xsll.src_a = SRC_A_SHAMT; e_xsll.src_b = SRC_B_Q2; e_xsll.aluc = ALUC_SLL;
        e_xori = '0; e_xori.src_a = SRC_A_Q1; e_xori.src_b = SRC_B_IMM; e_xori.aluc = ALUC_OR;
        e_xori.sext = 1'b0; e_xori.regrt = 1'b1;

        e_wbr = '0; e_wbr.reg_write = 1'b1; e_wbr.aluc = ALUC_ADD;
        e_wbi = e_wbr; e_wbi.regrt = 1'b1;
        e_wbm = e_wbi; e_wbm.mem2reg = 1'b1;

        e_maddr = '0; e_maddr.src_a = SRC_A_Q1; e_maddr.src_b = SRC_B_IMM;
        e_maddr.sext = 1'b1; e_maddr.aluc = ALUC_ADD;
        e_mrd = '0; e_mrd.iord = 1'b1; e_mrd.mem_read = 1'b1; e_mrd.aluc = ALUC_ADD;
        e_mwr = '0; e_mwr.iord = 1'b1; e_mwr.mem_write = 1'b1; e_mwr.aluc = ALUC_ADD;

        e_brn = '0; e_brn.src_a = SRC_A_Q1; e_brn.src_b = SRC_B_Q2;
        e_brn.aluc = ALUC_SUB; e_brn.pc_src = PC_SRC_BRANCH;
        e_brt = e_brn; e_brt.pc_write = 1'b1;
        e_jmp = '0; e_jmp.pc_src = PC_SRC_JUMP; e_jmp.pc_write = 1'b1; e_jmp.aluc = ALUC_ADD;

        e_flt1 = '0; e_flt1.aluc = ALUC_ADD; e_flt1.fault = 1'b1; e_flt1.fault_code = FAULT_ILLEGAL;
        e_flt2 = e_flt1; e_flt2.fault_code = FAULT_BUS;

        //    run  op        func    zero rdy  expected  instret name
        add(1'b1, OP_RTYPE, FN_ADD, 1'b0, 1'b1, e_idle,  32'd0, "idle_go");
        add(1'b1, OP_RTYPE, FN_ADD, 1'b0, 1'b1, e_fr,    32'd0, "add_fetch");
        add(1'b1, OP_RTYPE, FN_ADD, 1'b0, 1'b1, e_dec,   32'd0, "add_decode");
        add(1'b1, OP_RTYPE, FN_ADD, 1'b0, 1'b1, e_xadd,  32'd0, "add_exec");
        add(1'b1, OP_RTYPE, FN_ADD, 1'b0, 1'b1, e_wbr,   32'd0, "add_wb");
        add(1'b1, OP_LW,    6'd0,   1'b0, 1'b1, e_fr,    32'd1, "lw_fetch");
        add(1'b1, OP_LW,    6'd0,   1'b0, 1'b1, e_dec,   32'd1, "lw_decode");
        add(1'b1, OP_LW,    6'd0,   1'b0, 1'b1, e_maddr, 32'd1, "lw_addr");
        add(1'b1, OP_LW,    6'd0,   1'b0, 1'b0, e_mrd,   32'd1, "lw_rd_wait1");
        add(1'b1, OP_LW,    6'd0,   1'b0, 1'b0, e_mrd,   32'd1, "lw_rd_wait2");
        add(1'b1, OP_LW,    6'd0,   1'b0, 1'b0, e_mrd,   32'd1, "lw_rd_wait3");
        add(1'b1, OP_LW,    6'd0,   1'b0, 1'b1, e_mrd,   32'd1, "lw_rd_done");
        add(1'b1, OP_LW,    6'd0,   1'b0, 1'b1, e_wbm,   32'd1, "lw_wb");
        add(1'b1, OP_BEQ,   6'd0,   1'b1, 1'b1, e_fr,    32'd2, "beq_fetch");
        add(1'b1, OP_BEQ,   6'd0,   1'b1, 1'b1, e_dec,   32'd2, "beq_decode");
        add(1'b1, OP_BEQ,   6'd0,   1'b1, 1'b1, e_brt,   32'd2, "beq_taken");
        add(1'b1, OP_BNE,   6'd0,   1'b1, 1'b1, e_fr,    32'd3, "bne_fetch");
        add(1'b1, OP_BNE,   6'd0,   1'b1, 1'b1, e_dec,   32'd3, "bne_decode");
        add(1'b1, OP_BNE,   6'd0,   1'b1, 1'b1, e_brn,   32'd3, "bne_not_taken");
        add(1'b1, OP_J,     6'd0,   1'b0, 1'b1, e_fr,    32'd4, "j_fetch");
        add(1'b1, OP_J,     6'd0,   1'b0, 1'b1, e_dec,   32'd4, "j_decode");
        add(1'b1, OP_J,     6'd0,   1'b0, 1'b1, e_jmp,   32'd4, "j_jump");
        add(1'b1, OP_ORI,   6'd0,   1'b0, 1'b1, e_fr,    32'd5, "ori_fetch");
        add(1'b1, OP_ORI,   6'd0,   1'b0, 1'b1, e_dec,   32'd5, "ori_decode");
        add(1'b1, OP_ORI,   6'd0,   1'b0, 1'b1, e_xori,  32'd5, "ori_exec");
        add(1'b1, OP_ORI,   6'd0,   1'b0, 1'b1, e_wbi,   32'd5, "ori_wb");
        add(1'b1, OP_SW,    6'd0,   1'b0, 1'b0, e_fw,    32'd6, "sw_fetch_wait");
        add(1'b1, OP_SW,    6'd0,   1'b0, 1'b1, e_fr,    32'd6, "sw_fetch");
        add(1'b0, OP_SW,    6'd0,   1'b0, 1'b1, e_dec,   32'd6, "sw_decode");
        add(1'b0, OP_SW,    6'd0,   1'b0, 1'b1, e_maddr, 32'd6, "sw_addr");
        add(1'b0, OP_SW,    6'd0,   1'b0, 1'b0, e_mwr,   32'd6, "sw_wr_wait");
        add(1'b0, OP_SW,    6'd0,   1'b0, 1'b1, e_mwr,   32'd6, "sw_wr_done");
        add(1'b0, OP_RTYPE, FN_SLL, 1'b0, 1'b1, e_idle,  32'd7, "idle_hold1");
        add(1'b0, OP_RTYPE, FN_SLL, 1'b0, 1'b1, e_idle,  32'd7, "idle_hold2");
        add(1'b1, OP_RTYPE, FN_SLL, 1'b0, 1'b1, e_idle,  32'd7, "idle_restart");
        add(1'b1, OP_RTYPE, FN_SLL, 1'b0, 1'b1, e_fr,    32'd7, "sll_fetch");
        add(1'b1, OP_RTYPE, FN_SLL, 1'b0, 1'b1, e_dec,   32'd7, "sll_decode");
        add(1'b1, OP_RTYPE, FN_SLL, 1'b0, 1'b1, e_xsll,  32'd7, "sll_exec");
        add(1'b1, OP_RTYPE, FN_SLL, 1'b0, 1'b1, e_wbr,   32'd7, "sll_wb");

        do_reset();

        for (int i = 0; i < tbl.size(); i++)
            cycle(tbl[i].run, tbl[i].op, tbl[i].func, tbl[i].zero, tbl[i].rdy,
                  tbl[i].ctl, tbl[i].instret, tbl[i].name);

        // Illegal opcode: trap on u_dut, retired as NOP on u_dut_nop.
        cycle(1'b1, 6'h3f, 6'd0, 1'b0, 1'b1, e_fr,   32'd8, "ill_fetch");
        cycle(1'b1, 6'h3f, 6'd0, 1'b0, 1'b1, e_dec,  32'd8, "ill_decode");
        cycle(1'b1, 6'h3f, 6'd0, 1'b0, 1'b1, e_flt1, 32'd8, "ill_fault");
        check("nop_instret", d1_instret, 32'd9);
        check("nop_fetching", 32'({d1_mem_read, d1_fault, d1_halted}), 32'b100);
        cycle(1'b1, OP_RTYPE, FN_ADD, 1'b0, 1'b1, e_flt1, 32'd8, "fault_hold1");
        cycle(1'b1, OP_RTYPE, FN_ADD, 1'b0, 1'b1, e_flt1, 32'd8, "fault_hold2");

        // Bus timeout: 15 consecutive not-ready fetch cycles.
        do_reset();
        cycle(1'b1, OP_RTYPE, FN_ADD, 1'b0, 1'b0, e_idle, 32'd0, "to_idle");
        for (int i = 0; i < 15; i++)
            cycle(1'b1, OP_RTYPE, FN_ADD, 1'b0, 1'b0, e_fw, 32'd0, "to_wait");
        cycle(1'b1, OP_RTYPE, FN_ADD, 1'b0, 1'b1, e_flt2, 32'd0, "to_fault");
        cycle(1'b1, OP_RTYPE, FN_ADD, 1'b0, 1'b1, e_flt2, 32'd0, "to_ignore_run");

        // Reset asserted while a store is on the bus.
        do_reset();
        cycle(1'b1, OP_RTYPE, FN_ADD, 1'b0, 1'b1, e_idle,  32'd0, "rw_idle");
        cycle(1'b1, OP_RTYPE, FN_ADD, 1'b0, 1'b1, e_fr,    32'd0, "rw_add_fetch");
        cycle(1'b1, OP_RTYPE, FN_ADD, 1'b0, 1'b1, e_dec,   32'd0, "rw_add_decode");
        cycle(1'b1, OP_RTYPE, FN_ADD, 1'b0, 1'b1, e_xadd,  32'd0, "rw_add_exec");
        cycle(1'b1, OP_RTYPE, FN_ADD, 1'b0, 1'b1, e_wbr,   32'd0, "rw_add_wb");
        cycle(1'b1, OP_SW,    6'd0,   1'b0, 1'b1, e_fr,    32'd1, "rw_sw_fetch");
        cycle(1'b1, OP_SW,    6'd0,   1'b0, 1'b1, e_dec,   32'd1, "rw_sw_decode");
        cycle(1'b1, OP_SW,    6'd0,   1'b0, 1'b1, e_maddr, 32'd1, "rw_sw_addr");
        cycle(1'b1, OP_SW,    6'd0,   1'b0, 1'b0, e_mwr,   32'd1, "rw_sw_write");
        #2;
        rst = 1'b1;
        #1;
        check("rw_mem_write_dropped", 32'(d0_mem_write), 32'd0);
        check("rw_halted", 32'(d0_halted), 32'd1);
        check("rw_instret", d0_instret, 32'd0);
        check("rw_ctl_idle", 32'(d0_ctl), 32'(e_idle));
        @(negedge clk);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
